// File: rtl/tk_sync_call_arbiter.sv
// tk_sync_call_arbiter
//   Clocked N-way round-robin arbiter plus call controller. It shares one
//   four-phase resource port between N four-phase requesters. Exactly one
//   requester is granted at a time. Its handshake is forwarded to the resource,
//   and a one-hot select drives the datapath mux.
//
// Ports
//   clk      in   rising-edge system clock
//   reset_n  in   asynchronous active-low reset
//   r_req    in   [N] per-requester four-phase request
//   r_ack    out  [N] per-requester four-phase acknowledge (at most one bit high)
//   s_req    out  four-phase request to the shared resource
//   s_ack    in   four-phase acknowledge from the shared resource
//   sel      out  [N] one-hot select of the granted requester, zero when idle
//   busy     out  high whenever the controller is not idle
//
// Parameters
//   N   number of requesters (2..16)
//   PW  pointer width, must equal ceil(log2(N))
//
// Build option
//   SYNC_EN  when defined, each r_req bit and s_ack pass through a 2-flop
//            synchroniser reset to 0. Every req/ack-driven latency then grows
//            by 2 cycles.
module tk_sync_call_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] r_req,
    output logic [N-1:0] r_ack,
    output logic         s_req,
    input  logic         s_ack,
    output logic [N-1:0] sel,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_RTZ  = 2'd3;

    localparam int unsigned NU = N;

    // Effective request/acknowledge seen by the FSM
    logic [N-1:0] w_req;
    logic         w_ack;

`ifdef SYNC_EN
    logic [N-1:0] r_req_s1;
    logic [N-1:0] r_req_s2;
    logic         r_sack_s1;
    logic         r_sack_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_s1  <= '0;
            r_req_s2  <= '0;
            r_sack_s1 <= 1'b0;
            r_sack_s2 <= 1'b0;
        end else begin
            r_req_s1  <= r_req;
            r_req_s2  <= r_req_s1;
            r_sack_s1 <= s_ack;
            r_sack_s2 <= r_sack_s1;
        end
    end

    assign w_req = r_req_s2;
    assign w_ack = r_sack_s2;
`else
    assign w_req = r_req;
    assign w_ack = s_ack;
`endif

    logic [1:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_g;
    logic [N-1:0]  r_sel;
    logic [N-1:0]  r_ack_o;
    logic          r_sreq;

    // Round-robin winner: first set request at ptr, ptr+1, ... wrapping mod N
    logic [PW-1:0] w_win;
    logic          w_found;
    logic [31:0]   w_sum;
    logic [PW-1:0] w_cand;

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            w_sum = 32'(r_ptr) + i;
            if (w_sum >= NU) begin
                w_sum = w_sum - NU;
            end
            w_cand = PW'(w_sum);
            if (!w_found && w_req[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
            r_sel   <= '0;
            r_ack_o <= '0;
            r_sreq  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_g     <= w_win;
                        r_sel   <= {{(N-1){1'b0}}, 1'b1} << w_win;
                        r_sreq  <= 1'b1;
                        r_state <= ST_CALL;
                    end
                end
                ST_CALL: begin
                    if (w_ack) begin
                        // r_sel already holds onehot(g), so it doubles as the ack mask
                        r_ack_o <= r_sel;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!w_req[r_g]) begin
                        r_sreq  <= 1'b0;
                        r_state <= ST_RTZ;
                    end
                end
                default: begin
                    if (!w_ack) begin
                        r_ack_o <= '0;
                        r_sel   <= '0;
                        r_ptr   <= (r_g == PW'(N - 1)) ? '0 : r_g + 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign r_ack = r_ack_o;
    assign s_req = r_sreq;
    assign sel   = r_sel;
    assign busy  = (r_state != ST_IDLE);

endmodule
